rr_arbiter_weighted_slice: RTL
==============================

Name: rr_arbiter_weighted_slice

Overview:
Parametrised N-way round-robin arbiter with a programmable time slice per requester.
- The owner holds the grant for up to its own slice length, then the grant rotates to the next active requester in circular order.
- A lock input lets the current owner extend its tenure for bursts.
- The grant is registered. It sits in front of shared resources (bus, memory port) in the arbiter library.

Parameters:
N, 4, number of requesters (2..16)
CW, 4, width of each slice-length field and of the slice counter
IW, $clog2(N), width of the grant index

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  request vector; bit k = requester k
slice_len  input  N*CW  slice length for requester k at [k*CW +: CW], in cycles; 0 is treated as 1
lock  input  1  when high, the owner's slice counter freezes and there is no rotation
gnt  output  N  one-hot grant, registered; all zeros when idle
gnt_id  output  IW  index of the current owner; holds the last owner when idle
gnt_valid  output  1  high when gnt is non-zero

Behaviour:
- Reset (async, immediate, also mid-grant):
  - gnt=0, gnt_id=0, gnt_valid=0.
  - Internal search pointer ptr=0, slice counter cnt=0, state=IDLE.
- States: IDLE, GRANT.
- Search function: first k with req[k]=1, scanning ptr, ptr+1, … mod N.
- On any grant to k:
  - gnt<=onehot(k), gnt_id<=k, gnt_valid<=1.
  - cnt<=max(slice_len[k],1); ptr<=(k+1) mod N.
  - slice_len is sampled only at this edge; later changes do not affect the current slice.
- IDLE:
  - req==0 -> stay IDLE.
  - Otherwise grant the search winner at the next edge. Latency is 1 cycle from req to gnt.
- GRANT, owner k, evaluated at each rising edge:
  - req[k]=0: release. If another request is active, grant the search winner (ptr=k+1) at this edge with no idle bubble. Otherwise go to IDLE and clear gnt and gnt_valid. This rule has priority over expiry and lock.
  - req[k]=1, lock=1: hold the grant; cnt unchanged.
  - req[k]=1, lock=0, cnt>1: cnt<=cnt-1; hold.
  - req[k]=1, lock=0, cnt==1 (slice expiry): grant the search winner over requesters other than k. If none is requesting, re-grant k and reload cnt from slice_len[k].
- Resulting guarantees:
  - An uninterrupted, unlocked owner holds gnt for exactly max(slice_len[k],1) consecutive cycles.
  - Lock cycles extend the hold 1:1.
- Simultaneous events:
  - New requests arriving mid-slice never preempt the owner.
  - Expiry coinciding with the owner dropping req follows the release rule.
- Wrap-around: ptr wraps N-1 -> 0. cnt never underflows; its minimum is 1 in GRANT.
- Invariants:
  - gnt is zero or one-hot.
  - gnt_valid == |gnt.
  - gnt[k] is never newly asserted while req[k]=0.

Test Plan:
- Reset; req=0001, all slices=3, lock=0 -> gnt=0001 from the first edge after req. It stays continuously asserted (re-grant on expiry) with no zero cycle.
- req=1111, slice_len {k0=1,k1=2,k2=3,k3=4} -> repeating gnt pattern 0001×1, 0010×2, 0100×3, 1000×4; gnt_id follows 0,1,1,2,2,2,3,3,3,3.
- req=0110, slice_len[1]=0, slice_len[2]=2 -> gnt 0010×1, 0100×2, repeating; a zero slice behaves as 1.
- req=0011, slices=5; drop req[0] after 2 grant cycles -> gnt=0010 at the next edge, held for 5 cycles; never an all-zero cycle.
- req=0011, slice0=2; assert lock for 6 cycles starting at owner 0's first grant cycle -> gnt=0001 for 8 cycles total (6 frozen + 2 counted), then 0010.
- Owner 2 mid-slice, rst_n pulsed low asynchronously -> gnt=0 and gnt_valid=0 immediately. After release with req=1111, the first grant is 0001 (ptr=0).

Source files
------------

// File: rtl/rr_arbiter_weighted_slice.sv
// Purpose: N-way round-robin arbiter; each owner holds the grant for its own programmable slice, and lock extends the hold.
// Latency: 1 cycle from request to registered grant; a hand-off on release or expiry happens with no idle bubble.
// Backpressure: none; lock freezes the owner's slice counter, and requesters wait on req until granted.
module rr_arbiter_weighted_slice #(
  parameter int N  = 4,
  parameter int CW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*CW-1:0] slice_len,
  input  logic            lock,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            gnt_valid
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Search results: first requester found scanning circularly from ptr.
  logic          found;
  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic [CW-1:0] win_len;
  logic          owner_req;

  // Circular search starting at ptr. On expiry, ptr already points one past
  // the owner, so the owner is naturally visited last and is only re-chosen
  // when nobody else is requesting.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr_q) + i) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Slice length of the search winner, with a zero length treated as one cycle.
  always_comb begin
    win_len = slice_len[int'(win)*CW +: CW];
    if (win_len == '0) begin
      win_len = CW'(1);
    end
  end

  assign owner_req = req[gnt_id_q];

  // Next-state logic: release has priority over lock and expiry.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = GRANT;
          gnt_d         = '0;
          gnt_d[win]    = 1'b1;
          gnt_id_d      = win;
          cnt_d         = win_len;
          ptr_d         = (win == IW'(N-1)) ? '0 : win + 1'b1;
        end
      end
      GRANT: begin
        if (!owner_req || (!lock && cnt_q <= CW'(1))) begin
          // Release or expiry: hand over to the search winner, or go idle.
          if (found) begin
            gnt_d         = '0;
            gnt_d[win]    = 1'b1;
            gnt_id_d      = win;
            cnt_d         = win_len;
            ptr_d         = (win == IW'(N-1)) ? '0 : win + 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (!lock) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and grant registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;

endmodule
